// File: rtl/ddr3_app_pkg.sv
// rtl/ddr3_app_pkg.sv - shared definitions for the DDR3 app-interface model
// Purpose: command encodings, controller state enum and app address field
// offsets used by ddr3_memory_interface_top.
package ddr3_app_pkg;

  localparam logic [2:0] CMD_WR = 3'd0;
  localparam logic [2:0] CMD_RD = 3'd1;

  // App address layout {rank, bank[2:0], row[13:0], col[9:0]}
  localparam int COL_LSB  = 0;
  localparam int ROW_LSB  = 10;
  localparam int BANK_LSB = 24;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_RD_WAIT,
    ST_READ,
    ST_MAINT
  } state_t;

endpackage

// File: rtl/ddr3_app_ram.sv
// rtl/ddr3_app_ram.sv - byte-maskable word storage with registered read port
// Purpose: DEPTH x WIDTH storage backing the app interface.
// Ports: clk, rst_n (async, clears only the read register),
//   we/waddr/wdata/be (single write port, be[i] = 1 writes byte i),
//   re/raddr/rdata (rdata updates one edge after re).
module ddr3_app_ram #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] be,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is not reset; its contents are undefined after reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < WIDTH / 8; b++) begin
        if (be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ddr3_memory_interface_top.sv
// rtl/ddr3_memory_interface_top.sv - DDR3 app-interface model on on-chip storage
// Purpose: presents the vendor DDR3 controller app handshake (calibration,
// command port, masked write port, read stream, refresh/self-refresh) backed
// by ddr3_app_ram.
// Ports: clk/rst_n/pll_lock in; clk_out, ddr_rst, init_calib_complete out;
//   cmd_en/cmd/addr/app_burst_number/burst in, cmd_ready out;
//   wr_data/wr_data_en/wr_data_end/wr_data_mask in, wr_data_rdy out;
//   rd_data/rd_data_valid/rd_data_end out; sr_req/ref_req in, sr_ack/ref_ack out.
module ddr3_memory_interface_top
  import ddr3_app_pkg::*;
#(
  parameter int WIDTH        = 128,
  parameter int DDR3_ADDR    = 28,
  parameter int MEM_DEPTH    = 256,
  parameter int CALIB_CYCLES = 16,
  parameter int READ_LAT     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pll_lock,
  output logic                 clk_out,
  output logic                 ddr_rst,
  output logic                 init_calib_complete,
  output logic                 cmd_ready,
  input  logic                 cmd_en,
  input  logic [2:0]           cmd,
  input  logic [DDR3_ADDR-1:0] addr,
  input  logic [5:0]           app_burst_number,
  input  logic                 burst,
  output logic                 wr_data_rdy,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 wr_data_en,
  input  logic                 wr_data_end,
  input  logic [WIDTH/8-1:0]   wr_data_mask,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_data_valid,
  output logic                 rd_data_end,
  input  logic                 sr_req,
  input  logic                 ref_req,
  output logic                 sr_ack,
  output logic                 ref_ack
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CAL_W = $clog2(CALIB_CYCLES + 1);
  localparam int LAT_W = $clog2(READ_LAT);

  state_t           state;
  logic [CAL_W-1:0] cal_cnt;
  logic [LAT_W-1:0] wait_cnt;
  logic [IDX_W-1:0] idx;        // next word index for the active burst
  logic [6:0]       remaining;  // beats still to transfer in the active burst

  logic [IDX_W-1:0] cmd_idx;
  logic [6:0]       cmd_beats;
  logic             cmd_accept, wr_cmd, rd_cmd, beat;
  logic             ram_we, ram_re;
  logic [IDX_W-1:0] ram_waddr;
  logic             unused_bits;

  assign clk_out     = clk;
  assign ddr_rst     = (state == ST_INIT);
  assign cmd_ready   = init_calib_complete & (state == ST_IDLE) & ~sr_req & ~ref_req;
  assign wr_data_rdy = init_calib_complete & ((state == ST_IDLE) | (state == ST_WRITE));
  assign rd_data_end = rd_data_valid;

  // The column's low 3 bits select within a BL8, so one word covers 8 columns.
  assign cmd_idx    = addr[3 +: IDX_W];
  assign cmd_beats  = burst ? ({1'b0, app_burst_number} + 7'd1) : 7'd1;
  assign cmd_accept = cmd_en & cmd_ready;
  assign wr_cmd     = cmd_accept & (cmd == CMD_WR);
  assign rd_cmd     = cmd_accept & (cmd == CMD_RD);
  assign beat       = wr_data_en & wr_data_rdy;

  // A beat in IDLE is stored only when it rides along with a write command.
  assign ram_we    = beat & (wr_cmd | (state == ST_WRITE));
  assign ram_waddr = (state == ST_WRITE) ? idx : cmd_idx;
  assign ram_re    = (state == ST_READ);

  assign unused_bits = ^{addr[2:0], addr[DDR3_ADDR-1:3+IDX_W], wr_data_end};

  ddr3_app_ram #(
    .WIDTH(WIDTH),
    .DEPTH(MEM_DEPTH)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(wr_data),
    .be   (~wr_data_mask),
    .re   (ram_re),
    .raddr(idx),
    .rdata(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_INIT;
      cal_cnt             <= '0;
      wait_cnt            <= '0;
      idx                 <= '0;
      remaining           <= '0;
      init_calib_complete <= 1'b0;
      rd_data_valid       <= 1'b0;
      sr_ack              <= 1'b0;
      ref_ack             <= 1'b0;
    end else begin
      sr_ack        <= 1'b0;
      ref_ack       <= 1'b0;
      rd_data_valid <= 1'b0;
      if (!pll_lock) begin
        state               <= ST_INIT;
        cal_cnt             <= '0;
        init_calib_complete <= 1'b0;
      end else begin
        case (state)
          ST_INIT: begin
            if (cal_cnt == CAL_W'(CALIB_CYCLES)) begin
              state               <= ST_IDLE;
              init_calib_complete <= 1'b1;
              cal_cnt             <= '0;
            end else begin
              cal_cnt <= cal_cnt + 1'b1;
            end
          end
          ST_IDLE: begin
            // Refresh wins over self-refresh when both are pending.
            if (ref_req) begin
              state   <= ST_MAINT;
              ref_ack <= 1'b1;
            end else if (sr_req) begin
              state  <= ST_MAINT;
              sr_ack <= 1'b1;
            end else if (wr_cmd) begin
              idx       <= cmd_idx + IDX_W'(beat);
              remaining <= cmd_beats - 7'(beat);
              if (!(beat && cmd_beats == 7'd1)) state <= ST_WRITE;
            end else if (rd_cmd) begin
              idx       <= cmd_idx;
              remaining <= cmd_beats;
              // RAM read adds one edge; the READ entry edge adds another.
              wait_cnt  <= LAT_W'(READ_LAT - 2);
              state     <= ST_RD_WAIT;
            end
          end
          ST_WRITE: begin
            if (beat) begin
              idx       <= idx + 1'b1;
              remaining <= remaining - 7'd1;
              if (remaining == 7'd1) state <= ST_IDLE;
            end
          end
          ST_RD_WAIT: begin
            if (wait_cnt == '0) state <= ST_READ;
            else wait_cnt <= wait_cnt - 1'b1;
          end
          ST_READ: begin
            rd_data_valid <= 1'b1;
            idx           <= idx + 1'b1;
            remaining     <= remaining - 7'd1;
            if (remaining == 7'd1) state <= ST_IDLE;
          end
          ST_MAINT: state <= ST_IDLE;
          default:  state <= ST_INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr3_memory_interface_top.sv
// tb/tb_ddr3_memory_interface_top.sv - self-checking bench for ddr3_memory_interface_top
module tb_ddr3_memory_interface_top;

  localparam int READ_LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n, pll_lock;
  logic         clk_out, ddr_rst, init_calib_complete, cmd_ready;
  logic         cmd_en, burst, wr_data_rdy, wr_data_en, wr_data_end;
  logic [2:0]   cmd;
  logic [27:0]  addr;
  logic [5:0]   app_burst_number;
  logic [127:0] wr_data, rd_data;
  logic [15:0]  wr_data_mask;
  logic         rd_data_valid, rd_data_end, sr_req, ref_req, sr_ack, ref_ack;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ddr3_memory_interface_top dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .clk_out(clk_out),
    .ddr_rst(ddr_rst), .init_calib_complete(init_calib_complete),
    .cmd_ready(cmd_ready), .cmd_en(cmd_en), .cmd(cmd), .addr(addr),
    .app_burst_number(app_burst_number), .burst(burst),
    .wr_data_rdy(wr_data_rdy), .wr_data(wr_data), .wr_data_en(wr_data_en),
    .wr_data_end(wr_data_end), .wr_data_mask(wr_data_mask),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_end(rd_data_end),
    .sr_req(sr_req), .ref_req(ref_req), .sr_ack(sr_ack), .ref_ack(ref_ack)
  );

  typedef struct {
    logic         do_wr;
    logic [27:0]  a;
    logic [127:0] d;
    logic [15:0]  m;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int t = 0;
    while (!cmd_ready && t < 200) begin
      tick();
      t++;
    end
    if (!cmd_ready) check({nm, "_ready_timeout"}, 0, 1);
  endtask

  // Write n beats d0, d0+1, ... starting at a; beat 0 goes with the command.
  task automatic write_burst(input string nm, input logic [27:0] a, input int n,
                             input logic [127:0] d0, input logic [15:0] m, input bit gap);
    wait_ready(nm);
    cmd_en = 1'b1; cmd = 3'd0; addr = a; burst = (n > 1);
    app_burst_number = (n > 1) ? 6'(n - 1) : 6'd5;
    wr_data_en = 1'b1; wr_data = d0; wr_data_mask = m;
    tick();
    cmd_en = 1'b0;
    for (int k = 1; k < n; k++) begin
      if (gap) begin
        wr_data_en = 1'b0;
        tick();
        wr_data_en = 1'b1;
      end
      wr_data = d0 + 128'(k);
      tick();
    end
    wr_data_en = 1'b0;
  endtask

  // Read n beats from a, expecting d0, d0+1, ... at exactly READ_LAT edges after accept.
  task automatic read_check(input string nm, input logic [27:0] a, input int n,
                            input logic [127:0] d0);
    wait_ready(nm);
    cmd_en = 1'b1; cmd = 3'd1; addr = a; burst = (n > 1);
    app_burst_number = 6'(n - 1);
    tick();
    cmd_en = 1'b0;
    for (int k = 1; k <= READ_LAT + n; k++) begin
      tick();
      if (k >= READ_LAT && k < READ_LAT + n) begin
        check({nm, "_valid"}, rd_data_valid, 1);
        check({nm, "_end"}, rd_data_end, 1);
        check({nm, "_data"}, rd_data, d0 + 128'(k - READ_LAT));
      end else begin
        check({nm, "_idle_valid"}, rd_data_valid, 0);
      end
    end
  endtask

  task automatic calib_check(input string nm);
    for (int k = 1; k <= 17; k++) begin
      tick();
      check({nm, "_calib"}, init_calib_complete, (k == 17));
      if (k == 16) check({nm, "_ready_early"}, cmd_ready, 0);
    end
    check({nm, "_cmd_ready"}, cmd_ready, 1);
    check({nm, "_wr_rdy"}, wr_data_rdy, 1);
    check({nm, "_ddr_rst"}, ddr_rst, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 28'h040, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 16'h0000,
                128'h1111_2222_3333_4444_5555_6666_7777_8888};
    vecs[1] = '{1'b1, 28'h040, {128{1'b1}}, 16'h00FF,
                128'hFFFF_FFFF_FFFF_FFFF_5555_6666_7777_8888};
    vecs[2] = '{1'b1, 28'h847, 128'hA5A5_A5A5_A5A5_A5A5_0F0F_0F0F_C3C3_C3C3, 16'hFF00,
                128'hFFFF_FFFF_FFFF_FFFF_0F0F_0F0F_C3C3_C3C3};
    vecs[3] = '{1'b1, 28'h048, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 16'h0000,
                128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF};
    vecs[4] = '{1'b1, 28'h048, 128'h0, 16'h5555,
                128'h0011_0033_0055_0077_0099_00BB_00DD_00FF};
    vecs[5] = '{1'b0, 28'h000, 128'h0, 16'h0000,
                128'h0123_4567_890A_BCDE_FEDC_BA98_7654_3210};
    vecs[6] = '{1'b0, 28'h038, 128'h0, 16'h0000,
                128'h0123_4567_890A_BCDE_FEDC_BA98_7654_3217};
    vecs[7] = '{1'b0, 28'h847, 128'h0, 16'h0000,
                128'hFFFF_FFFF_FFFF_FFFF_0F0F_0F0F_C3C3_C3C3};
    vecs[8] = '{1'b1, 28'h7F8, 128'hCAFE_0000_0000_0000_0000_0000_0000_BEEF, 16'h0000,
                128'hCAFE_0000_0000_0000_0000_0000_0000_BEEF};

    rst_n = 1'b0; pll_lock = 1'b0; cmd_en = 1'b0; cmd = 3'd2; addr = '0;
    app_burst_number = '0; burst = 1'b0; wr_data = '0; wr_data_en = 1'b0;
    wr_data_end = 1'b1; wr_data_mask = '0; sr_req = 1'b0; ref_req = 1'b0;

    #20;
    check("rst_calib", init_calib_complete, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_wr_rdy", wr_data_rdy, 0);
    check("rst_rd_valid", rd_data_valid, 0);
    check("rst_rd_end", rd_data_end, 0);
    check("rst_acks", {sr_ack, ref_ack}, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_ddr_rst", ddr_rst, 1);
    #2 rst_n = 1'b1;
    #75 pll_lock = 1'b1;
    calib_check("init");

    write_burst("wr8", 28'h000, 8, 128'h0123_4567_890A_BCDE_FEDC_BA98_7654_3210, 16'h0, 1'b0);
    read_check("rd8", 28'h000, 8, 128'h0123_4567_890A_BCDE_FEDC_BA98_7654_3210);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_wr) write_burst($sformatf("vec%0d", i), vecs[i].a, 1, vecs[i].d, vecs[i].m, 1'b0);
      read_check($sformatf("vec%0d", i), vecs[i].a, 1, vecs[i].exp);
    end

    // Burst across the top of storage, with idle cycles between beats.
    write_burst("wrap_wr", 28'h7F0, 4, 128'h7777_0000_0000_0000_0000_0000_0000_0000, 16'h0, 1'b1);
    read_check("wrap_rd", 28'h7F0, 4, 128'h7777_0000_0000_0000_0000_0000_0000_0000);
    read_check("wrap_idx0", 28'h000, 1, 128'h7777_0000_0000_0000_0000_0000_0000_0002);
    read_check("wrap_idx1", 28'h008, 1, 128'h7777_0000_0000_0000_0000_0000_0000_0003);

    // Maintenance: both requests held, refresh acknowledged first.
    ref_req = 1'b1; sr_req = 1'b1;
    #1 check("maint_ready_blocked", cmd_ready, 0);
    tick();
    check("maint_ref_ack", {sr_ack, ref_ack}, 2'b01);
    check("maint_ready0", cmd_ready, 0);
    ref_req = 1'b0;
    tick();
    check("maint_gap_acks", {sr_ack, ref_ack}, 2'b00);
    check("maint_ready1", cmd_ready, 0);
    tick();
    check("maint_sr_ack", {sr_ack, ref_ack}, 2'b10);
    sr_req = 1'b0;
    tick();
    check("maint_done_acks", {sr_ack, ref_ack}, 2'b00);
    check("maint_ready_back", cmd_ready, 1);

    // No-op command is accepted and leaves the block idle.
    cmd_en = 1'b1; cmd = 3'd5;
    tick();
    cmd_en = 1'b0;
    for (int k = 0; k < READ_LAT + 1; k++) begin
      tick();
      check("noop_valid", rd_data_valid, 0);
    end
    check("noop_ready", cmd_ready, 1);

    // Lose lock in the middle of a read burst.
    wait_ready("lock");
    cmd_en = 1'b1; cmd = 3'd1; addr = 28'h000; burst = 1'b1; app_burst_number = 6'd7;
    tick();
    cmd_en = 1'b0;
    for (int k = 1; k <= READ_LAT + 1; k++) tick();
    check("lock_mid_valid", rd_data_valid, 1);
    pll_lock = 1'b0;
    tick();
    check("lock_drop_valid", rd_data_valid, 0);
    check("lock_drop_calib", init_calib_complete, 0);
    check("lock_drop_ddr_rst", ddr_rst, 1);
    check("lock_drop_ready", cmd_ready, 0);
    tick(); tick();
    pll_lock = 1'b1;
    calib_check("recal");
    read_check("post_recal", 28'h000, 1, 128'h7777_0000_0000_0000_0000_0000_0000_0002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
